// File: rtl/seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// seq_chunk_adder
//
// Multi-cycle adder/subtractor. Two WIDTH-bit operands are added (or
// subtracted) CHUNK bits per clock, with the carry between chunks held in a
// register. This keeps the carry chain short, so wide operations close timing.
// Operations are accepted and results are returned with a valid/ready
// handshake on each side. Operations never overlap.
//
// Parameters
//   WIDTH      operand/result width; must be a multiple of CHUNK
//   CHUNK      bits processed per cycle (1 <= CHUNK <= WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/mode present this cycle
//   in_ready   block can accept an operation (high only when idle)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in, add mode only
//   sub        0 = a+b+cin, 1 = a-b (cin ignored)
//   out_valid  result valid; held until out_ready
//   out_ready  downstream accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry-out; in subtract mode 1 means no borrow (a >= b)
//   ovf        signed two's-complement overflow
// ---------------------------------------------------------------------------
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  // Keep the chunk index at least one bit wide so NCHUNK=1 still elaborates.
  localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CHUNK:0]   chunkRes;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  //
  // The operand registers shift right by CHUNK each busy cycle, so the chunk
  // being processed is always in the low CHUNK bits. On the final chunk those
  // low bits hold the operand MSB chunk. The sign bits needed for the overflow
  // test are therefore a_q[CHUNK-1] and b_q[CHUNK-1], and no extra registers
  // are needed for them.
  //
  // Subtraction is a + ~b + 1. The inversion and the forced carry-in are
  // applied once, when the operation is accepted.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    chunkRes = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
             + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunkRes[CHUNK];
        for (int k = 0; k < NCHUNK; k++) begin
          if (idx_q == IDXW'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = chunkRes[CHUNK-1:0];
          end
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = chunkRes[CHUNK];
          ovf_d   = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                    (chunkRes[CHUNK-1] != a_q[CHUNK-1]);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// ---------------------------------------------------------------------------
// tb_seq_chunk_adder
//
// Self-checking bench for seq_chunk_adder with WIDTH=8. Four instances are
// built, with CHUNK = 1, 2, 4 and 8. Each instance has its own slot in the
// signal arrays below. Instance 1 (CHUNK=2) carries the directed tests.
// All four instances get randomized operations, which are compared against
// an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_seq_chunk_adder;

  localparam int NINST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inValid  [NINST];
  logic       inReady  [NINST];
  logic [7:0] aArr     [NINST];
  logic [7:0] bArr     [NINST];
  logic       cinArr   [NINST];
  logic       subArr   [NINST];
  logic       outValid [NINST];
  logic       outReady [NINST];
  logic [7:0] sumArr   [NINST];
  logic       coutArr  [NINST];
  logic       ovfArr   [NINST];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] expSum;
    logic       expCout;
    logic       expOvf;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NINST; g++) begin : gInst
    seq_chunk_adder #(
      .WIDTH(8),
      .CHUNK(1 << g)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (inValid[g]),
      .in_ready (inReady[g]),
      .a        (aArr[g]),
      .b        (bArr[g]),
      .cin      (cinArr[g]),
      .sub      (subArr[g]),
      .out_valid(outValid[g]),
      .out_ready(outReady[g]),
      .sum      (sumArr[g]),
      .cout     (coutArr[g]),
      .ovf      (ovfArr[g])
    );
  end

  // Compare one observed value against the expected value and tally the result.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Arithmetic reference model, written with plain integer arithmetic.
  // cout means a true carry past 255 when adding, and a >= b when subtracting.
  // ovf means the true signed result falls outside [-128, 127].
  function automatic void refModel(input logic [7:0] av, input logic [7:0] bv,
                                   input logic cv, input logic sv,
                                   output logic [7:0] s, output logic co,
                                   output logic ov);
    int ua, ub, sa, sb, r, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (sv) begin
      r  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(cv);
      co = (r > 255);
      sr = sa + sb + int'(cv);
    end
    s  = 8'(r);
    ov = (sr > 127) || (sr < -128);
  endfunction

  // Run one complete operation on instance j. Call this #1 after a rising edge
  // while the instance is idle.
  //
  // The task checks, in order:
  //   - in_ready while idle and while busy;
  //   - the latency of the operation;
  //   - during the hold cycles, that the result stays stable while the inputs
  //     are toggled;
  //   - the return to idle after the result is consumed.
  //
  // If earlyReady is set, out_ready is raised together with in_valid. In that
  // case DONE must still last at least one cycle.
  task automatic applyStimulus(input int j, input logic [7:0] av,
                               input logic [7:0] bv, input logic cv,
                               input logic sv, input int hold,
                               input logic earlyReady,
                               output logic [7:0] rs, output logic rc,
                               output logic ro);
    int lat;
    checkOutput("in_ready_idle", 32'(inReady[j]), 32'd1);
    aArr[j]     = av;
    bArr[j]     = bv;
    cinArr[j]   = cv;
    subArr[j]   = sv;
    inValid[j]  = 1'b1;
    outReady[j] = earlyReady;
    @(posedge clk);
    #1;
    inValid[j] = 1'($urandom);
    aArr[j]    = 8'($urandom);
    bArr[j]    = 8'($urandom);
    cinArr[j]  = 1'($urandom);
    subArr[j]  = 1'($urandom);
    checkOutput("in_ready_busy", 32'(inReady[j]), 32'd0);
    lat = 0;
    while (outValid[j] !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(8 >> j));
    rs = sumArr[j];
    rc = coutArr[j];
    ro = ovfArr[j];
    if (hold > 0) outReady[j] = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      inValid[j] = 1'b1;
      aArr[j]    = ~av;
      checkOutput("hold_out_valid", 32'(outValid[j]), 32'd1);
      checkOutput("hold_in_ready", 32'(inReady[j]), 32'd0);
      checkOutput("hold_sum", 32'(sumArr[j]), 32'(rs));
      checkOutput("hold_cout", 32'(coutArr[j]), 32'(rc));
    end
    outReady[j] = 1'b1;
    @(posedge clk);
    #1;
    inValid[j]  = 1'b0;
    outReady[j] = 1'b0;
    checkOutput("consumed_out_valid", 32'(outValid[j]), 32'd0);
    checkOutput("consumed_in_ready", 32'(inReady[j]), 32'd1);
    checkOutput("consumed_sum_kept", 32'(sumArr[j]), 32'(rs));
  endtask

  // Global time bound in case a wait is ever left open.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rs, es;
    logic       rc, ro, ec, eo;
    logic [7:0] av, bv;
    logic       cv, sv, early;
    int         hold;

    vecs[0] = '{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h20, 8'h20, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{8'h00, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    for (int i = 0; i < NINST; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b0;
      aArr[i]     = 8'h00;
      bArr[i]     = 8'h00;
      cinArr[i]   = 1'b0;
      subArr[i]   = 1'b0;
    end

    // Reset state, checked on every instance.
    rst_n = 1'b0;
    #2;
    for (int i = 0; i < NINST; i++) begin
      checkOutput("reset_out_valid", 32'(outValid[i]), 32'd0);
      checkOutput("reset_sum", 32'(sumArr[i]), 32'd0);
      checkOutput("reset_cout", 32'(coutArr[i]), 32'd0);
      checkOutput("reset_ovf", 32'(ovfArr[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NINST; i++) begin
      checkOutput("release_in_ready", 32'(inReady[i]), 32'd1);
    end

    // Table-driven directed vectors on the CHUNK=2 instance.
    for (int v = 0; v < 10; v++) begin
      applyStimulus(1, vecs[v].a, vecs[v].b, vecs[v].cin, vecs[v].sub,
                    v % 2, 1'b0, rs, rc, ro);
      checkOutput("vec_sum", 32'(rs), 32'(vecs[v].expSum));
      checkOutput("vec_cout", 32'(rc), 32'(vecs[v].expCout));
      checkOutput("vec_ovf", 32'(ro), 32'(vecs[v].expOvf));
    end

    // Asynchronous reset in the middle of an operation. The chunks already
    // written are nonzero, and cout/ovf are still set from the previous
    // operation, so a reset that fails to clear them is visible.
    aArr[1]    = 8'h55;
    bArr[1]    = 8'hAA;
    cinArr[1]  = 1'b0;
    subArr[1]  = 1'b0;
    inValid[1] = 1'b1;
    @(posedge clk);
    #1;
    inValid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(outValid[1]), 32'd0);
    checkOutput("midreset_sum", 32'(sumArr[1]), 32'd0);
    checkOutput("midreset_cout", 32'(coutArr[1]), 32'd0);
    checkOutput("midreset_ovf", 32'(ovfArr[1]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midreset_in_ready", 32'(inReady[1]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checkOutput("midreset_no_result", 32'(outValid[1]), 32'd0);
    end

    // Hold DONE for 5 cycles, then issue back-to-back operations. The second
    // one raises out_ready early.
    applyStimulus(1, 8'h5A, 8'h3C, 1'b1, 1'b0, 5, 1'b0, rs, rc, ro);
    checkOutput("hs_sum", 32'(rs), 32'h97);
    checkOutput("hs_cout", 32'(rc), 32'd0);
    checkOutput("hs_ovf", 32'(ro), 32'd1);
    applyStimulus(1, 8'hFF, 8'h01, 1'b0, 1'b0, 0, 1'b1, rs, rc, ro);
    checkOutput("b2b_sum", 32'(rs), 32'h00);
    checkOutput("b2b_cout", 32'(rc), 32'd1);
    checkOutput("b2b_ovf", 32'(ro), 32'd0);

    // Randomized sweep over CHUNK = 1, 2, 4 and 8, with 250 operations each.
    for (int j = 0; j < NINST; j++) begin
      for (int n = 0; n < 250; n++) begin
        av    = 8'($urandom);
        bv    = 8'($urandom);
        cv    = 1'($urandom);
        sv    = 1'($urandom);
        early = ($urandom_range(0, 3) == 0);
        hold  = early ? 0 : int'($urandom_range(0, 2));
        applyStimulus(j, av, bv, cv, sv, hold, early, rs, rc, ro);
        refModel(av, bv, cv, sv, es, ec, eo);
        checkOutput("rand_sum", 32'(rs), 32'(es));
        checkOutput("rand_cout", 32'(rc), 32'(ec));
        checkOutput("rand_ovf", 32'(ro), 32'(eo));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
